freq_div_sched: RTL and testbench

Round-robin scheduler that shares one frequency-divider instance among NUM_REQ requesters. It arbitrates requests and latches the winner's divisor and run length. It then sequences the divider's configure/enable protocol: disable, load while disabled, enable for a fixed cycle count, then release. It sits between the requester blocks and the divider's Din/ConfigDiv/Enable inputs.

---
 rtl/freq_div_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/freq_div_sched.sv | 138 +++++++++++++
 tb/tb_freq_div_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and helpers for freq_div_sched: FSM state encoding, default
// widths and the round-robin one-hot pick used by rr_arbiter.
package freq_div_pkg;

  localparam int DIV_W_DEF = 32;
  localparam int MAX_REQ   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STOP,
    S_LOAD,
    S_RUN,
    S_DONE
  } fds_state_e;

  // First set bit of req scanning upward from ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] gnt;
    logic [2:0]         idx;
    gnt = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (i < n && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

  function automatic int unsigned onehot_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// priority pointer moves past the winner whenever the grant is accepted.
module rr_arbiter
  import freq_div_pkg::*;
#(
  parameter int NUM_REQ = 4
)(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       accept,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign any       = |req;
  assign grant_idx = PTR_W'(onehot_idx(rr_onehot(req_ext, 3'(ptr), NUM_REQ)));

  always_comb begin
    grant            = '0;
    grant[grant_idx] = any;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      ptr <= '0;
    else if (accept && any)
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/freq_div_sched.sv
// Shares one frequency divider among NUM_REQ requesters: round-robin grant,
// then STOP -> LOAD -> RUN -> DONE on the divider's config/enable inputs.
// FDS_ZERO_CHECK_EN: reject divisor-0 winners with an Error pulse instead of clamping to 1.
module freq_div_sched
  import freq_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = DIV_W_DEF
)(
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*DIV_W-1:0] ReqDiv,
  input  logic [NUM_REQ*DIV_W-1:0] ReqCycles,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Done,
  output logic                     Busy,
  output logic [DIV_W-1:0]         DivDin,
  output logic                     DivConfig,
  output logic                     DivEnable
`ifdef FDS_ZERO_CHECK_EN
  ,
  output logic                     Error
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  fds_state_e state, state_d;

  logic [NUM_REQ-1:0][DIV_W-1:0] div_arr, cyc_arr;
  logic [NUM_REQ-1:0]            arb_gnt;
  logic [PTR_W-1:0]              arb_idx;
  logic                          arb_any;
  logic [DIV_W-1:0]              win_div, win_cyc, div_q, cyc_q, cnt;
  logic                          go, reject, owner_req, run_last;

  logic [NUM_REQ-1:0] grant_d, done_d;
  logic [DIV_W-1:0]   din_d;
  logic               busy_d, cfg_d, en_d;

  assign div_arr = ReqDiv;
  assign cyc_arr = ReqCycles;
  assign win_div = div_arr[arb_idx];
  assign win_cyc = cyc_arr[arb_idx];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (Req),
    .accept    (state == S_IDLE),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

`ifdef FDS_ZERO_CHECK_EN
  assign reject = arb_any && (win_div == '0);
`else
  assign reject = 1'b0;
`endif

  assign go        = (state == S_IDLE) && arb_any && !reject;
  // Only the owner's Req matters once granted; others wait for IDLE.
  assign owner_req = |(Req & Grant);
  assign run_last  = (cnt == cyc_q - DIV_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (go) state_d = S_STOP;
      S_STOP: state_d = S_LOAD;
      S_LOAD: state_d = (cyc_q == '0) ? S_DONE : S_RUN;
      S_RUN:  if (!owner_req || run_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so nothing reaches them combinationally.
  always_comb begin
    grant_d = Grant;
    if (state == S_IDLE)        grant_d = go ? arb_gnt : '0;
    else if (state_d == S_IDLE) grant_d = '0;
    done_d = '0;
    if (state_d == S_DONE) done_d = Grant;
    else if (reject)       done_d = arb_gnt;
    busy_d = (state_d != S_IDLE);
    cfg_d  = (state_d == S_LOAD);
    en_d   = (state_d == S_RUN);
    din_d  = (state_d == S_LOAD) ? div_q : DivDin;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Grant     <= '0;
      Done      <= '0;
      Busy      <= 1'b0;
      DivDin    <= '0;
      DivConfig <= 1'b0;
      DivEnable <= 1'b0;
    end else begin
      Grant     <= grant_d;
      Done      <= done_d;
      Busy      <= busy_d;
      DivDin    <= din_d;
      DivConfig <= cfg_d;
      DivEnable <= en_d;
    end
  end

`ifdef FDS_ZERO_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset) Error <= 1'b0;
    else       Error <= reject;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q <= '0;
      cyc_q <= '0;
      cnt   <= '0;
    end else begin
      if (go) begin
        div_q <= (win_div == '0) ? DIV_W'(1) : win_div;
        cyc_q <= win_cyc;
      end
      cnt <= (state == S_RUN) ? cnt + DIV_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_freq_div_sched.sv
// Scoreboard bench for freq_div_sched: expected runs queued at stimulus time,
// checked against each Done pulse; plus edge-accurate timing checks.
module tb_freq_div_sched;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int          idx;
    logic [31:0] div;
    int          en;
    bit          err;
  } exp_t;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] ReqDiv = '0;
  logic [N*W-1:0] ReqCycles = '0;
  logic [N-1:0]   Grant, Done;
  logic           Busy, DivConfig, DivEnable;
  logic [W-1:0]   DivDin;
`ifdef FDS_ZERO_CHECK_EN
  logic           Error;
`endif

  freq_div_sched #(.NUM_REQ(N), .DIV_W(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req       (Req),
    .ReqDiv    (ReqDiv),
    .ReqCycles (ReqCycles),
    .Grant     (Grant),
    .Done      (Done),
    .Busy      (Busy),
    .DivDin    (DivDin),
    .DivConfig (DivConfig),
    .DivEnable (DivEnable)
`ifdef FDS_ZERO_CHECK_EN
    ,
    .Error     (Error)
`endif
  );

  always #5 Clk = ~Clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] c);
    ReqDiv[i*W +: W]    = d;
    ReqCycles[i*W +: W] = c;
  endtask

  task automatic push(input int idx, input logic [31:0] div, input int en, input bit err);
    exp_t e;
    e.idx = idx; e.div = div; e.en = en; e.err = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_done(input logic [N-1:0] oh);
    int k = 0;
    do begin
      tick();
      k++;
    end while (Done == '0 && k < 400);
    chk("done_owner", 64'(Done), 64'(oh));
  endtask

  // Monitor: tracks the last configured divisor and enable length, scores each Done.
  initial begin
    logic [31:0] cfg_din;
    int          en_cnt;
    exp_t        e;
    cfg_din = '0;
    en_cnt  = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        en_cnt = 0;
      end else begin
        chk("cfg_en_excl", 64'(DivConfig & DivEnable), 0);
        if (DivConfig) begin
          cfg_din = DivDin;
          en_cnt  = 0;
        end
        if (DivEnable) en_cnt++;
        if (Done != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(Done), 0);
          end else begin
            e = sb.pop_front();
            chk("sb_done_idx", 64'(Done), 64'(1) << e.idx);
            if (e.err) begin
`ifdef FDS_ZERO_CHECK_EN
              chk("sb_error", 64'(Error), 1);
`endif
            end else begin
              chk("sb_din", 64'(cfg_din), 64'(e.div));
              chk("sb_en_cycles", 64'(en_cnt), 64'(e.en));
            end
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    // Reset values
    tick();
    tick();
    chk("rst_grant", 64'(Grant), 0);
    chk("rst_done", 64'(Done), 0);
    chk("rst_busy", 64'(Busy), 0);
    chk("rst_din", 64'(DivDin), 0);
    chk("rst_cfg", 64'(DivConfig), 0);
    chk("rst_en", 64'(DivEnable), 0);
`ifdef FDS_ZERO_CHECK_EN
    chk("rst_error", 64'(Error), 0);
`endif
    Reset = 1'b0;
    tick();

    // Single request, divisor 4, run length 10
    set_req(0, 4, 10);
    push(0, 4, 10, 0);
    Req = 4'b0001;
    tick();
    chk("t1_e1_grant", 64'(Grant), 64'h1);
    chk("t1_e1_busy", 64'(Busy), 1);
    chk("t1_e1_cfg", 64'(DivConfig), 0);
    tick();
    chk("t1_e2_cfg", 64'(DivConfig), 1);
    chk("t1_e2_din", 64'(DivDin), 4);
    chk("t1_e2_en", 64'(DivEnable), 0);
    for (int e = 3; e <= 12; e++) begin
      tick();
      chk("t1_run_en", 64'(DivEnable), 1);
    end
    tick();
    chk("t1_e13_done", 64'(Done), 64'h1);
    chk("t1_e13_en", 64'(DivEnable), 0);
    chk("t1_e13_grant", 64'(Grant), 64'h1);
    Req = '0;
    tick();
    chk("t1_e14_busy", 64'(Busy), 0);
    chk("t1_e14_grant", 64'(Grant), 0);
    chk("t1_e14_din_hold", 64'(DivDin), 4);

    // Fairness: all held, run length 2
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 2), 2);
    for (int k = 0; k < 5; k++) push(order[k], 32'(order[k] + 2), 2, 0);
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(4'(1 << order[k]));
      if (k == 4) Req = '0;
    end
    tick();
    tick();
    chk("t2_idle_busy", 64'(Busy), 0);

    // Zero run length
    do_reset();
    set_req(2, 7, 0);
    push(2, 7, 0, 0);
    Req = 4'b0100;
    tick();
    chk("t3_e1_grant", 64'(Grant), 64'h4);
    tick();
    chk("t3_e2_cfg", 64'(DivConfig), 1);
    chk("t3_e2_din", 64'(DivDin), 7);
    tick();
    chk("t3_e3_done", 64'(Done), 64'h4);
    chk("t3_e3_en", 64'(DivEnable), 0);
    Req = '0;
    tick();
    chk("t3_e4_busy", 64'(Busy), 0);

    // Early drop at RUN cycle 5
    do_reset();
    set_req(1, 3, 100);
    push(1, 3, 6, 0);
    Req = 4'b0010;
    repeat (8) tick();
    chk("t4_e8_en", 64'(DivEnable), 1);
    Req = '0;
    tick();
    chk("t4_e9_en", 64'(DivEnable), 0);
    chk("t4_e9_done", 64'(Done), 64'h2);
    tick();
    chk("t4_e10_busy", 64'(Busy), 0);

    // Reset at RUN cycle 3, then pointer must be back at 0
    do_reset();
    set_req(0, 5, 20);
    set_req(1, 9, 1);
    Req = 4'b0001;
    repeat (6) tick();
    chk("t5_e6_en", 64'(DivEnable), 1);
    Reset = 1'b1;
    tick();
    chk("t5_rst_grant", 64'(Grant), 0);
    chk("t5_rst_done", 64'(Done), 0);
    chk("t5_rst_busy", 64'(Busy), 0);
    chk("t5_rst_en", 64'(DivEnable), 0);
    chk("t5_rst_cfg", 64'(DivConfig), 0);
    chk("t5_rst_din", 64'(DivDin), 0);
    Reset = 1'b0;
    Req = 4'b0011;
    push(0, 5, 20, 0);
    push(1, 9, 1, 0);
    tick();
    chk("t5_regrant", 64'(Grant), 64'h1);
    wait_done(4'b0001);
    Req = 4'b0010;
    wait_done(4'b0010);
    Req = '0;
    tick();

    // Divisor 0
    do_reset();
    set_req(3, 0, 3);
    Req = 4'b1000;
`ifdef FDS_ZERO_CHECK_EN
    push(3, 0, 0, 1);
    tick();
    chk("t6_error", 64'(Error), 1);
    chk("t6_done", 64'(Done), 64'h8);
    chk("t6_busy", 64'(Busy), 0);
    Req = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_cfg", 64'(DivConfig), 0);
      chk("t6_no_busy", 64'(Busy), 0);
    end
`else
    push(3, 1, 3, 0);
    tick();
    tick();
    chk("t6_cfg", 64'(DivConfig), 1);
    chk("t6_din_clamp", 64'(DivDin), 1);
    wait_done(4'b1000);
    Req = '0;
`endif
    repeat (4) tick();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
